// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I field-to-instruction encoder feeding an imem write port
//
// Packs decoded field bundles (format, opcode, funct3/7, registers, full immediate)
// into 32-bit RV32I words and writes them to sequential word addresses.
// Bundles with out-of-range immediates or illegal formats are consumed but dropped,
// setting a sticky error flag.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 pulse: clear count/error, restart at BASE_ADDR
//   i_in_valid / o_in_ready field bundle handshake
//   i_fmt                   0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//   i_op, i_funct3, i_funct7, i_rs1, i_rs2, i_rd, i_imm   field bundle
//   o_wr_valid / i_wr_ready imem write handshake
//   o_wr_addr, o_wr_data    byte address (word aligned) and encoded instruction
//   o_count                 words written since start (saturates at DEPTH)
//   o_done                  loader full
//   o_err, o_err_index      sticky reject flag and count at first reject
module instr_encoder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [2:0]    i_fmt,
  input  logic [6:0]    i_op,
  input  logic [2:0]    i_funct3,
  input  logic [6:0]    i_funct7,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic [4:0]    i_rd,
  input  logic [31:0]   i_imm,
  output logic          o_wr_valid,
  input  logic          i_wr_ready,
  output logic [31:0]   o_wr_addr,
  output logic [31:0]   o_wr_data,
  output logic [CW-1:0] o_count,
  output logic          o_done,
  output logic          o_err,
  output logic [CW-1:0] o_err_index
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_wr_valid;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [CW-1:0] r_err_index;

  logic          w_fire;
  logic          w_in_ready;
  logic          w_accept;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_count_inc;
  logic          w_legal;
  logic [31:0]   w_enc;
  logic          w_imm12_ok;
  logic          w_imm13_ok;
  logic          w_imm21_ok;

  assign w_fire      = r_wr_valid && i_wr_ready;
  // Words committed or in flight; the extra bit keeps the DEPTH compare overflow-free.
  assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_wr_valid};
  assign w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
  assign w_accept    = i_in_valid && w_in_ready;

  // An immediate fits in N signed bits when all bits from N-1 upward agree.
  assign w_imm12_ok = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign w_imm13_ok = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign w_imm21_ok = (&i_imm[31:20]) || !(|i_imm[31:20]);

  always_comb begin
    w_enc   = 32'h0;
    w_legal = 1'b0;
    case (i_fmt)
      3'd0: begin
        w_enc   = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
        w_legal = 1'b1;
      end
      3'd1: begin
        w_enc   = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
        w_legal = w_imm12_ok;
      end
      3'd2: begin
        w_enc   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
        w_legal = w_imm12_ok;
      end
      3'd3: begin
        w_enc   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], i_op};
        w_legal = w_imm13_ok && !i_imm[0];
      end
      3'd4: begin
        w_enc   = {i_imm[31:12], i_rd, i_op};
        w_legal = (i_imm[11:0] == 12'h0);
      end
      3'd5: begin
        w_enc   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
        w_legal = w_imm21_ok && !i_imm[0];
      end
      default: begin
        w_enc   = 32'h0;
        w_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b0;
      end
      S_LOAD: begin
        w_in_ready = (!r_wr_valid || i_wr_ready) && (w_occ < DEPTH_X);
        if (w_fire && (w_count_inc == DEPTH_X)) begin
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        w_in_ready = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (i_start) begin
      w_state_next = S_LOAD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= BASE_ADDR;
      r_wr_data   <= 32'h0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_index <= '0;
    end else if (i_start) begin
      // A pending write is abandoned; the data register is simply left stale.
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= BASE_ADDR;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_index <= '0;
    end else begin
      if (w_fire) begin
        r_count   <= w_count_inc[CW-1:0];
        r_wr_addr <= r_wr_addr + 32'd4;
      end
      if (w_accept) begin
        // Accept implies the output register is empty or draining this edge.
        if (w_legal) begin
          r_wr_valid <= 1'b1;
          r_wr_data  <= w_enc;
        end else begin
          r_wr_valid <= 1'b0;
          r_err      <= 1'b1;
          if (!r_err) begin
            r_err_index <= r_count;
          end
        end
      end else if (w_fire) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_count     = r_count;
  assign o_done      = (r_state == S_FULL);
  assign o_err       = r_err;
  assign o_err_index = r_err_index;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized scoreboard bench for instr_encoder
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  f3 = 3'd0;
  logic [6:0]  f7 = 7'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [10:0] count;
  logic        done;
  logic        err;
  logic [10:0] err_index;

  logic        start4 = 1'b0;
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic        wr_valid4;
  logic        wr_ready4 = 1'b1;
  logic [31:0] wr_addr4;
  logic [31:0] wr_data4;
  logic [2:0]  count4;
  logic        done4;
  logic        err4;
  logic [2:0]  err_index4;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int n_legal = 0;
  bit any_err = 0;
  int first_err_idx = 0;
  logic [63:0] sbq[$];
  int acc4 = 0;
  int nw4 = 0;
  logic [31:0] exp4 = 32'h0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(1024), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_fmt(fmt), .i_op(op), .i_funct3(f3), .i_funct7(f7),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_imm(imm),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_count(count), .o_done(done), .o_err(err), .o_err_index(err_index)
  );

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(start4),
    .i_in_valid(in_valid4), .o_in_ready(in_ready4),
    .i_fmt(fmt), .i_op(op), .i_funct3(f3), .i_funct7(f7),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_imm(imm),
    .o_wr_valid(wr_valid4), .i_wr_ready(wr_ready4),
    .o_wr_addr(wr_addr4), .o_wr_data(wr_data4),
    .o_count(count4), .o_done(done4), .o_err(err4), .o_err_index(err_index4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: legality from signed value ranges, encoding from shifts and masks.
  function automatic bit ref_legal(input logic [2:0] f, input logic [31:0] im);
    longint s;
    s = longint'($signed(im));
    case (f)
      3'd0: return 1'b1;
      3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd3: return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd4: return (im % 4096) == 0;
      3'd5: return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [6:0] o,
      input logic [2:0] ff3, input logic [6:0] ff7, input logic [4:0] r1,
      input logic [4:0] r2, input logic [4:0] rdd, input logic [31:0] im);
    logic [31:0] base_r;
    logic [31:0] w;
    base_r = (32'(r1) << 15) | (32'(ff3) << 12) | 32'(o);
    case (f)
      3'd0: w = (32'(ff7) << 25) | (32'(r2) << 20) | base_r | (32'(rdd) << 7);
      3'd1: w = ((im & 32'hFFF) << 20) | base_r | (32'(rdd) << 7);
      3'd2: w = (((im >> 5) & 32'h7F) << 25) | (32'(r2) << 20) | base_r | ((im & 32'h1F) << 7);
      3'd3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r2) << 20)
              | base_r | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      3'd4: w = (im & 32'hFFFFF000) | (32'(rdd) << 7) | 32'(o);
      default: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
              | (((im >> 11) & 32'h1) << 20) | (im & 32'h000FF000) | (32'(rdd) << 7) | 32'(o);
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [2:0] ff3,
      input logic [6:0] ff7, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rdd, input logic [31:0] im, input bit ovr, input logic [31:0] ovr_data);
    bit got;
    logic [31:0] e;
    fmt = f; op = o; f3 = ff3; f7 = ff7; rs1 = r1; rs2 = r2; rd = rdd; imm = im;
    in_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (ref_legal(f, im)) begin
        e = ovr ? ovr_data : ref_enc(f, o, ff3, ff7, r1, r2, rdd, im);
        sbq.push_back({BASE + 32'(n_legal) * 32'd4, e});
        n_legal++;
      end else begin
        if (!any_err) first_err_idx = n_legal;
        any_err = 1;
      end
    end
    tick();
  endtask

  task automatic stop_in();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    sbq.delete();
    n_legal = 0;
    any_err = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick();
      if (sbq.size() == 0 && !wr_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = ($urandom_range(0, 3) != 0);
        default: wr_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: a write fires on the coming edge when valid && ready now.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && wr_valid && wr_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_write", {wr_addr, wr_data}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e[63:32]));
          chk("wr_data", 64'(wr_data), 64'(e[31:0]));
        end
      end
      if (!reset && wr_valid4 && wr_ready4) begin
        chk("dut4_wr_addr", 64'(wr_addr4), 64'(nw4 * 4));
        chk("dut4_wr_data", 64'(wr_data4), 64'(exp4));
        nw4++;
      end
      if (!reset && in_valid4 && in_ready4) acc4++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] rim;
    logic [31:0] e;
    int          v;
    int          c_before;

    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err_index", 64'(err_index), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'(BASE));
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Directed encodings with known words
    rdy_mode = 0;
    do_start();
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1, 32'h00500093);
    stop_in();
    drain();
    chk("count_after_1", 64'(count), 64'd1);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 1, 32'h0020A423);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800, 1, 32'h001000EF);
    // Immediate boundaries that must be accepted
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4, 32'hFFFFF800, 0, 32'h0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4, 32'd2047, 0, 32'h0);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFF000, 0, 32'h0);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h000FFFFE, 0, 32'h0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'hABCDE000, 0, 32'h0);
    stop_in();
    drain();
    chk("count_after_dir", 64'(count), 64'(n_legal));

    // Backpressure: output register must hold for three stalled cycles
    rdy_mode = 2;
    c_before = n_legal;
    e = ref_enc(3'd0, 7'h33, 3'd5, 7'h20, 5'd11, 5'd12, 5'd13, 32'd0);
    send(3'd0, 7'h33, 3'd5, 7'h20, 5'd11, 5'd12, 5'd13, 32'd0, 0, 32'h0);
    stop_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_wr_valid", 64'(wr_valid), 64'd1);
      chk("stall_wr_data", 64'(wr_data), 64'(e));
      chk("stall_wr_addr", 64'(wr_addr), 64'(BASE + 32'(c_before) * 32'd4));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_count", 64'(count), 64'(c_before));
    end
    tick();
    rdy_mode = 0;
    drain();

    // Rejects: odd branch offset, then I immediate just out of range
    c_before = n_legal;
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3, 0, 32'h0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd2048, 0, 32'h0);
    stop_in();
    tick();
    tick();
    chk("rej_err", 64'(err), 64'd1);
    chk("rej_err_index", 64'(err_index), 64'(first_err_idx));
    chk("rej_count", 64'(count), 64'(c_before));

    // Start while a write is stalled drops it and rewinds to BASE
    rdy_mode = 2;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd9, 0, 32'h0);
    stop_in();
    tick();
    chk("pre_start_wr_valid", 64'(wr_valid), 64'd1);
    do_start();
    chk("post_start_wr_valid", 64'(wr_valid), 64'd0);
    chk("post_start_count", 64'(count), 64'd0);
    chk("post_start_err", 64'(err), 64'd0);
    rdy_mode = 0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd10, 0, 32'h0);
    stop_in();
    drain();
    chk("post_start_count1", 64'(count), 64'd1);

    // Randomized stream with random backpressure and gaps
    do_start();
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case (rf)
          3'd1, 3'd2: begin v = int'($urandom_range(0, 4095)) - 2048; rim = 32'(v); end
          3'd3: begin v = (int'($urandom_range(0, 8191)) - 4096) & ~1; rim = 32'(v); end
          3'd4: rim = $urandom & 32'hFFFFF000;
          3'd5: begin v = (int'($urandom_range(0, 2097151)) - 1048576) & ~1; rim = 32'(v); end
          default: rim = $urandom;
        endcase
      end else begin
        rim = $urandom;
      end
      send(rf, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), rim, 0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        stop_in();
        tick();
      end
    end
    stop_in();
    rdy_mode = 0;
    drain();
    chk("rand_count", 64'(count), 64'(n_legal));
    chk("rand_err", 64'(err), 64'(any_err));
    chk("rand_done", 64'(done), 64'd0);

    // DEPTH=4 instance: six offered bundles, four accepted, then FULL
    fmt = 3'd1; op = 7'h13; f3 = 3'd0; f7 = 7'd0; rs1 = 5'd2; rs2 = 5'd0; rd = 5'd3; imm = 32'd100;
    exp4 = ref_enc(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd3, 32'd100);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    in_valid4 = 1'b1;
    repeat (6) tick();
    in_valid4 = 1'b0;
    repeat (3) tick();
    chk("dut4_accepts", 64'(acc4), 64'd4);
    chk("dut4_writes", 64'(nw4), 64'd4);
    chk("dut4_count", 64'(count4), 64'd4);
    chk("dut4_done", 64'(done4), 64'd1);
    chk("dut4_in_ready", 64'(in_ready4), 64'd0);
    chk("dut4_wr_valid", 64'(wr_valid4), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
